// File: rtl/imm_extend_pipe.sv
// Immediate-generation stage: decodes MIPS opcode/funct into an XLEN-wide immediate or
// branch/jump target, behind a valid/ready handshake with a 2-entry skid buffer.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_mode,
    output logic            out_err
);

    localparam logic [2:0] MODE_NONE   = 3'd0;
    localparam logic [2:0] MODE_ZERO   = 3'd1;
    localparam logic [2:0] MODE_SIGN   = 3'd2;
    localparam logic [2:0] MODE_SHAMT  = 3'd3;
    localparam logic [2:0] MODE_UPPER  = 3'd4;
    localparam logic [2:0] MODE_BRANCH = 3'd5;
    localparam logic [2:0] MODE_JUMP   = 3'd6;

    logic [5:0]      op_s;
    logic [5:0]      funct_s;
    logic [XLEN-1:0] pc_inc_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_mode_s;
    logic            dec_err_s;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [2:0]      out_mode_q, out_mode_d;
    logic            out_err_q, out_err_d;
    logic            skid_full_q, skid_full_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]      skid_mode_q, skid_mode_d;
    logic            skid_err_q, skid_err_d;

    logic            accept_s;
    logic            load_out_s;

    assign op_s     = in_ir[31:26];
    assign funct_s  = in_ir[5:0];
    assign pc_inc_s = in_pc + XLEN'(PC_INC);

    // Opcode/funct decode into mode, immediate and error flag
    always_comb begin
        dec_imm_s  = {XLEN{1'b0}};
        dec_mode_s = MODE_NONE;
        dec_err_s  = 1'b0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h00, 6'h02, 6'h03: begin
                        dec_mode_s = MODE_SHAMT;
                        dec_imm_s  = XLEN'(in_ir[10:6]);
                    end
                    default: begin
                        dec_mode_s = MODE_NONE;
                        dec_imm_s  = {XLEN{1'b0}};
                    end
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_mode_s = MODE_ZERO;
                dec_imm_s  = XLEN'(in_ir[15:0]);
            end
            6'h0F: begin
                dec_mode_s = MODE_UPPER;
                dec_imm_s  = XLEN'($signed({in_ir[15:0], 16'h0000}));
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h21,
            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
                dec_mode_s = MODE_SIGN;
                dec_imm_s  = XLEN'($signed(in_ir[15:0]));
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec_mode_s = MODE_BRANCH;
                dec_imm_s  = pc_inc_s + XLEN'($signed({in_ir[15:0], 2'b00}));
            end
            6'h02, 6'h03: begin
                dec_mode_s = MODE_JUMP;
                dec_imm_s  = {pc_inc_s[XLEN-1:28], in_ir[25:0], 2'b00};
            end
            default: begin
                dec_mode_s = MODE_NONE;
                dec_err_s  = 1'b1;
            end
        endcase
    end

    // in_ready comes straight from a flop, so it never sees out_ready combinationally
    assign accept_s   = in_valid & ~skid_full_q;
    assign load_out_s = ~out_valid_q | out_ready;

    // Next-state for output and skid registers; flush overrides everything
    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_mode_d  = out_mode_q;
        out_err_d   = out_err_q;
        skid_full_d = skid_full_q;
        skid_imm_d  = skid_imm_q;
        skid_mode_d = skid_mode_q;
        skid_err_d  = skid_err_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (load_out_s) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_imm_d   = skid_imm_q;
                out_mode_d  = skid_mode_q;
                out_err_d   = skid_err_q;
                skid_full_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm_s;
                out_mode_d  = dec_mode_s;
                out_err_d   = dec_err_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_full_d = 1'b1;
                skid_imm_d  = dec_imm_s;
                skid_mode_d = dec_mode_s;
                skid_err_d  = dec_err_s;
            end else begin
                skid_full_d = skid_full_q;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= {XLEN{1'b0}};
            out_mode_q  <= 3'd0;
            out_err_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_imm_q  <= {XLEN{1'b0}};
            skid_mode_q <= 3'd0;
            skid_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_mode_q  <= out_mode_d;
            out_err_q   <= out_err_d;
            skid_full_q <= skid_full_d;
            skid_imm_q  <= skid_imm_d;
            skid_mode_q <= skid_mode_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign in_ready  = ~skid_full_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_mode  = out_mode_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate-generation stage between instruction fetch/decode and the ALU operand mux.
- Decodes the extension mode from the MIPS opcode and funct fields.
- Produces an XLEN-wide immediate, including pre-computed branch and jump targets.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream back-pressure is fully registered; supports pipeline flush.

Parameters:
- XLEN, 32, datapath/result width; legal values 32 or 64.
- PC_INC, 4, PC increment used for branch/jump base (pc + PC_INC).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; registered, equals !skid_full.
- in_ir  input  32  MIPS instruction word.
- in_pc  input  XLEN  address of the instruction.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate/target.
- out_mode  output  3  0 NONE, 1 ZERO, 2 SIGN, 3 SHAMT, 4 UPPER, 5 BRANCH, 6 JUMP.
- out_err  output  1  opcode/funct not in decode table.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all outputs and state are cleared:
  - out_valid=0, out_imm=0, out_mode=0, out_err=0.
  - in_ready=1 (skid empty); skid_full=0.
- Decode, combinational on in_ir; op=IR[31:26], funct=IR[5:0]:
  - op 0x00, funct in {0x00,0x02,0x03}: SHAMT, imm = zero-extend IR[10:6].
  - op 0x00, any other funct: NONE, imm=0, err=0.
  - op in {0x0C,0x0D,0x0E}: ZERO, imm = zero-extend IR[15:0].
  - op 0x0F: UPPER, imm = sign-extend {IR[15:0],16'h0} to XLEN.
  - op in {0x08,0x09,0x0A,0x0B,0x20,0x21,0x23,0x24,0x25,0x28,0x29,0x2B}: SIGN, imm = sign-extend IR[15:0].
  - op in {0x04,0x05,0x06,0x07}: BRANCH, imm = pc+PC_INC + (sext(IR[15:0])<<2).
  - op in {0x02,0x03}: JUMP, imm = {(pc+PC_INC)[XLEN-1:28], IR[25:0], 2'b00}.
  - Any other op: NONE, imm=0, err=1.
- Arithmetic: all adds are modulo 2^XLEN; wrap-around is silent, with no error flag.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Latency is 1 cycle: an accepted instruction appears on out_* the next cycle when the output register is empty or draining.
  - Output register loads when it is empty or out_ready=1.
  - Otherwise the accepted entry goes to the skid register, skid_full is set, and in_ready drops next cycle.
  - When the output drains with skid_full=1, skid moves to output and skid_full clears.
  - out_* stay stable while out_valid & !out_ready.
  - Ordering is strictly FIFO.
- Simultaneous accept and drain with skid empty: output reloads with the new entry and out_valid stays 1.
- Flush has priority over every other event:
  - Next cycle out_valid=0 and skid_full=0, so in_ready=1.
  - An input presented in the flush cycle is dropped, even if in_valid & in_ready.
  - out_imm/out_mode/out_err values after flush are don't-care while out_valid=0.
- Reset mid-operation: held entries are lost immediately; no output handshake completes.
- in_ready is a registered signal and never depends combinationally on out_ready.

Test Plan:
- Reset, then in_ir=0x2008FFFC (addi, imm -4), out_ready=1 -> next cycle out_valid=1, out_mode=2, out_imm=0xFFFFFFFC, out_err=0.
- Mode sweep with XLEN=32, pc=0x00400000:
  - ori 0x3508ABCD -> mode 1, imm 0x0000ABCD.
  - sll 0x00084140 -> mode 3, imm 0x00000005.
  - lui 0x3C088000 -> mode 4, imm 0x80000000.
  - beq 0x1000FFFF -> mode 5, imm 0x00400000.
  - j 0x08100004 -> mode 6, imm 0x00400010.
  - op 0x3F -> mode 0, err=1.
- Back-pressure: out_ready=0 with three back-to-back valids:
  - First accepted to output, second to skid, then in_ready=0 and the third is held.
  - Raising out_ready yields all three in order, one per cycle.
- Wrap-around: pc=0xFFFFFFFC with beq imm 0x0001 -> out_imm=0x00000004, err=0.
- Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flush-cycle instruction never appears at the output.
- XLEN=64: lui 0x3C08FFFF -> out_imm=0xFFFFFFFFFFFF0000; assert rst_n=0 asynchronously mid-stall -> out_valid drops without a clock edge.
